// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 fetch stage: owns the PC, fetches over ImemReq/ImemRdy, decodes sign-extender control, resolves branches (optional macro FETCH_TIMEOUT_EN adds an S_REQ timeout)
module fetch_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] StartPC,
  output logic        ImemReq,
  output logic [63:0] ImemAddr,
  input  logic        ImemRdy,
  input  logic [31:0] ImemData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [25:0] Imm,
  output logic [1:0]  ExtCtrl,
  output logic [63:0] CurrentPC,
  input  logic        Advance,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        Zero,
  input  logic [63:0] BusImm,
  output logic        FetchErr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] pc;

  logic        taken;
  logic [63:0] branch_target;
  logic [63:0] seq_pc;
  logic        target_misaligned;

  // Branch resolution is purely combinational on the current PC; the FSM
  // only commits the result when Advance is seen in S_VALID.
  assign taken             = Uncondbranch | (Branch & Zero);
  assign branch_target     = pc + BusImm;
  assign seq_pc            = pc + 64'd4;
  assign target_misaligned = taken && (branch_target[1:0] != 2'b00);

  assign ImemAddr  = pc;
  assign CurrentPC = pc;
  assign Imm       = Instr[25:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] timeout_cnt;
`else
  // Without the timeout feature the parameter has no consumer.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Extender control from the opcode, first match wins (B, CBZ/CBNZ, LDUR/STUR).
  always_comb begin
    ExtCtrl = 2'b00;
    if (Instr[31:26] == 6'b000101) begin
      ExtCtrl = 2'b10;
    end else if (Instr[31:25] == 7'b1011010) begin
      ExtCtrl = 2'b11;
    end else if ((Instr[31:21] == 11'b11111000010) ||
                 (Instr[31:21] == 11'b11111000000)) begin
      ExtCtrl = 2'b01;
    end
  end

  // Fetch FSM with registered ImemReq/InstrValid/FetchErr and the PC register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= S_IDLE;
      pc         <= StartPC;
      Instr      <= 32'd0;
      InstrValid <= 1'b0;
      ImemReq    <= 1'b0;
      FetchErr   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      timeout_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_REQ;
          ImemReq <= 1'b1;
        end

        S_REQ: begin
          if (ImemRdy) begin
            // Data arriving on the same edge as the timeout still wins.
            Instr      <= ImemData;
            state      <= S_VALID;
            ImemReq    <= 1'b0;
            InstrValid <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            timeout_cnt <= '0;
          end else if (timeout_cnt == CNT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th consecutive cycle without ImemRdy.
            state       <= S_FAULT;
            ImemReq     <= 1'b0;
            FetchErr    <= 1'b1;
            timeout_cnt <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
`endif
          end
        end

        S_VALID: begin
          if (Advance) begin
            InstrValid <= 1'b0;
            if (target_misaligned) begin
              // PC is left pointing at the offending instruction for debug.
              state    <= S_FAULT;
              FetchErr <= 1'b1;
            end else begin
              pc      <= taken ? branch_target : seq_pc;
              state   <= S_REQ;
              ImemReq <= 1'b1;
            end
          end
        end

        S_FAULT: begin
          ImemReq    <= 1'b0;
          InstrValid <= 1'b0;
          FetchErr   <= 1'b1;
        end

        default: begin
          state      <= S_IDLE;
          ImemReq    <= 1'b0;
          InstrValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
